// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues data-memory loads and stores, aligns and extends load data,
// registers the MEM/WB result, and drives the MEM forwarding taps and the pipeline stall.
module mem_stage #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ex_valid,
   input  logic [XLEN-1:0]           ex_alu_result,
   input  logic [XLEN-1:0]           ex_rs2_data,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic                      ex_reg_write,
   input  logic                      ex_mem_read,
   input  logic                      ex_mem_write,
   input  logic [2:0]                ex_funct3,
   output logic [XLEN-1:0]           mem_alu_result,
   output logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
   output logic                      mem_reg_write,
   output logic                      mem_stall,
   output logic                      dmem_req_valid,
   input  logic                      dmem_req_ready,
   output logic [XLEN-1:0]           dmem_addr,
   output logic                      dmem_we,
   output logic [3:0]                dmem_be,
   output logic [XLEN-1:0]           dmem_wdata,
   input  logic                      dmem_rsp_valid,
   input  logic [XLEN-1:0]           dmem_rdata,
   output logic                      wb_valid,
   output logic [XLEN-1:0]           wb_write_data,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
   output logic                      wb_reg_write,
   output logic                      misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t          state, state_nxt;
   logic            mem_op, mis, stall, req, mis_pulse, is_load;
   logic [1:0]      ofs;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] load_ext, load_buf;

   assign ofs     = ex_alu_result[1:0];
   assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
   assign is_load = ex_mem_read & ~ex_mem_write;

   assign mem_alu_result = ex_alu_result;
   assign mem_rd_addr    = ex_rd_addr;
   assign mem_reg_write  = ex_valid & ex_reg_write & ~ex_mem_read;

   assign dmem_addr = {ex_alu_result[XLEN-1:2], 2'b00};
   assign dmem_we   = ex_mem_write;

   // Unlisted size encodings behave as word accesses throughout.
   always_comb begin
      mis        = 1'b0;
      dmem_be    = 4'b1111;
      dmem_wdata = ex_rs2_data;
      case (ex_funct3[1:0])
         2'b00: begin
            dmem_wdata = {4{ex_rs2_data[7:0]}};
            if (ex_mem_write) dmem_be = 4'b0001 << ofs;
         end
         2'b01: begin
            mis        = ofs[0];
            dmem_wdata = {2{ex_rs2_data[15:0]}};
            if (ex_mem_write) dmem_be = 4'b0011 << ofs;
         end
         default: mis = |ofs;
      endcase
   end

   assign ld_byte = dmem_rdata[{ofs, 3'b000} +: 8];
   assign ld_half = ofs[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (ex_funct3)
         3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_ext = {24'b0, ld_byte};
         3'b101:  load_ext = {16'b0, ld_half};
         default: load_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      req       = 1'b0;
      mis_pulse = 1'b0;
      case (state)
         IDLE:
            if (mem_op) begin
               if (mis) mis_pulse = 1'b1;
               else begin
                  stall     = 1'b1;
                  state_nxt = REQ;
               end
            end
         REQ: begin
            stall = 1'b1;
            req   = 1'b1;
            if (dmem_req_ready) state_nxt = ex_mem_write ? DONE : RESP;
         end
         RESP: begin
            stall = 1'b1;
            if (dmem_rsp_valid) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Reset masks the combinational controls so an in-flight request drops at once.
   assign mem_stall      = stall & reset;
   assign dmem_req_valid = req & reset;
   assign misaligned     = mis_pulse & reset;

   always_ff @(posedge clk or negedge reset)
      if (!reset)                                 load_buf <= '0;
      else if (state == RESP && dmem_rsp_valid)   load_buf <= load_ext;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid      <= 1'b0;
         wb_reg_write  <= 1'b0;
         wb_write_data <= '0;
         wb_rd_addr    <= '0;
      end else if (stall) begin
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
      end else begin
         wb_valid      <= ex_valid;
         wb_reg_write  <= ex_valid & ex_reg_write & ~mis_pulse;
         wb_rd_addr    <= ex_rd_addr;
         wb_write_data <= (state == DONE && is_load) ? load_buf : ex_alu_result;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ALU/load/store traffic
// checked against an arithmetic reference of the access rules.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
   logic [31:0] ex_alu_result, ex_rs2_data;
   logic [4:0]  ex_rd_addr;
   logic [2:0]  ex_funct3;
   logic [31:0] mem_alu_result;
   logic [4:0]  mem_rd_addr;
   logic        mem_reg_write, mem_stall;
   logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_reg_write, misaligned;
   logic [31:0] wb_write_data;
   logic [4:0]  wb_rd_addr;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
      .mem_alu_result(mem_alu_result), .mem_rd_addr(mem_rd_addr),
      .mem_reg_write(mem_reg_write), .mem_stall(mem_stall),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_write_data(wb_write_data), .wb_rd_addr(wb_rd_addr),
      .wb_reg_write(wb_reg_write), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   // Reference load result: shift the addressed bytes down, mask to size, extend.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] ofs,
                                            input logic [31:0] word);
      int          sz;
      logic [31:0] mask, v;
      sz   = acc_size(f3);
      mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      v    = (word >> (8 * ofs)) & mask;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // One instruction held in EX/MEM until the stage releases it, then the WB result checked.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [4:0] rd, input logic rw_en, input logic ld, input logic st,
                        input int rwait, input int swait, input logic [31:0] rdata);
      int          sz, stalls, req_cyc, rsp_cyc, exp_stalls;
      logic        acc, done, mis;
      logic [7:0]  be_w;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata, exp_data;
      sz        = acc_size(f3);
      mis       = (ld | st) && (int'(addr[1:0]) % sz != 0);
      be_w      = ((8'd1 << sz) - 8'd1) << addr[1:0];
      exp_be    = st ? be_w[3:0] : 4'hF;
      exp_wdata = (sz == 1) ? rs2[7:0] * 32'h0101_0101 :
                  (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2;
      exp_stalls = mis ? 0 : st ? 2 + rwait : ld ? 3 + rwait + swait : 0;
      exp_data   = (ld && !st) ? ref_load(f3, addr[1:0], rdata) : addr;

      @(posedge clk); #1;
      ex_valid = 1'b1; ex_funct3 = f3; ex_alu_result = addr; ex_rs2_data = rs2;
      ex_rd_addr = rd; ex_reg_write = rw_en; ex_mem_read = ld; ex_mem_write = st;
      stalls = 0; req_cyc = 0; rsp_cyc = 0; acc = 1'b0; done = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         dmem_req_ready = 1'b0;
         dmem_rsp_valid = 1'b0;
         dmem_rdata     = $urandom;
         if (!mem_stall) done = 1'b1;
         else begin
            stalls++;
            if (dmem_req_valid) begin
               check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
               check("req_we", dmem_we, st);
               check("req_be", dmem_be, exp_be);
               if (st) check("req_wdata", dmem_wdata, exp_wdata);
               req_cyc++;
               if (req_cyc > rwait) begin dmem_req_ready = 1'b1; acc = 1'b1; end
            end else if (acc) begin
               rsp_cyc++;
               if (rsp_cyc > swait) begin dmem_rsp_valid = 1'b1; dmem_rdata = rdata; end
            end else dmem_rsp_valid = 1'($urandom_range(0, 1));
         end
      end
      check("released", done, 1'b1);
      check("stall_cycles", stalls, exp_stalls);
      check("misaligned", misaligned, mis);
      check("req_idle", dmem_req_valid, 1'b0);
      check("fwd_alu", mem_alu_result, addr);
      check("fwd_rd", mem_rd_addr, rd);
      check("fwd_we", mem_reg_write, rw_en & ~ld);
      @(posedge clk); #1;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      dmem_rsp_valid = 1'b0;
      check("wb_valid", wb_valid, 1'b1);
      check("wb_reg_write", wb_reg_write, rw_en & ~mis);
      check("wb_rd", wb_rd_addr, rd);
      if (!mis) check("wb_data", wb_write_data, exp_data);
   endtask

   initial begin
      reset = 1'b0;
      ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_alu_result = '0; ex_rs2_data = '0; ex_rd_addr = '0; ex_funct3 = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
      #12;
      check("rst_wb_valid", wb_valid, 1'b0);
      check("rst_wb_we", wb_reg_write, 1'b0);
      check("rst_wb_data", wb_write_data, 32'h0);
      check("rst_wb_rd", wb_rd_addr, 5'd0);
      check("rst_req", dmem_req_valid, 1'b0);
      check("rst_stall", mem_stall, 1'b0);
      check("rst_mis", misaligned, 1'b0);
      @(negedge clk); reset = 1'b1;

      // ADD, SB, LB/LBU with waits, misaligned LH, load forwarding tap, ALU rd=7
      do_op(3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
      do_op(3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0);
      do_op(3'b000, 32'h0000_0202, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2, 1, 32'h0080_0000);
      do_op(3'b100, 32'h0000_0202, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2, 1, 32'h0080_0000);
      do_op(3'b001, 32'h0000_0201, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0);
      do_op(3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 0, 0, 32'hCAFE_F00D);
      do_op(3'b000, 32'h0000_0077, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int          kind;
         logic [2:0]  f3;
         logic [31:0] a;
         kind = $urandom_range(0, 2);
         a    = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         case (kind)
            1: begin
               case ($urandom_range(0, 6))
                  0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
                  4: f3 = 3'b101; 5: f3 = 3'b011; default: f3 = 3'b110;
               endcase
               do_op(f3, a, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b0,
                     $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
            end
            2: begin
               f3 = 3'($urandom_range(0, 2));
               do_op(f3, a, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b1,
                     $urandom_range(0, 2), 0, 32'h0);
            end
            default:
               do_op(3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), 1'b0, 1'b0,
                     0, 0, 32'h0);
         endcase
      end

      // Reset while waiting for the load response
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_funct3 = 3'b010; ex_alu_result = 32'h0000_0400;
      ex_rd_addr = 5'd6; ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      @(negedge clk);
      @(negedge clk); dmem_req_ready = 1'b1;
      @(negedge clk); dmem_req_ready = 1'b0;
      check("resp_stall", mem_stall, 1'b1);
      reset = 1'b0; #1;
      check("mid_rst_stall", mem_stall, 1'b0);
      check("mid_rst_req", dmem_req_valid, 1'b0);
      check("mid_rst_wb_valid", wb_valid, 1'b0);
      check("mid_rst_mis", misaligned, 1'b0);
      ex_valid = 1'b0; ex_mem_read = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); dmem_rsp_valid = 1'b1; dmem_rdata = 32'h1234_5678;
      check("stray_stall", mem_stall, 1'b0);
      @(posedge clk); #1; dmem_rsp_valid = 1'b0;
      check("stray_wb_valid", wb_valid, 1'b0);
      do_op(3'b000, 32'h0000_00AB, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline; consumes the EX/MEM register contents produced by the execute stage. Issues loads and stores to the data memory over a valid/ready request channel plus a response channel, and aligns, sign/zero-extends and returns load data. Registers the MEM/WB result. Drives the MEM-stage forwarding taps and a stall back to the hazard logic.

## Interface
- XLEN, 32, datapath width
- REG_ADDR_WIDTH, 5, register-index width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM entry valid
- ex_alu_result  in  XLEN  ALU result / effective address
- ex_rs2_data  in  XLEN  store data
- ex_rd_addr  in  REG_ADDR_WIDTH  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign
- mem_alu_result  out  XLEN  forwarding tap = ex_alu_result
- mem_rd_addr  out  REG_ADDR_WIDTH  forwarding tap = ex_rd_addr
- mem_reg_write  out  1  ex_valid & ex_reg_write & ~ex_mem_read
- mem_stall  out  1  hold EX/MEM and upstream
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  XLEN  word address, bits [1:0] = 0
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  XLEN  load word
- wb_valid  out  1  MEM/WB entry valid
- wb_write_data  out  XLEN  ALU result or extended load data
- wb_rd_addr  out  REG_ADDR_WIDTH  destination
- wb_reg_write  out  1  write enable for WB
- misaligned  out  1  one-cycle pulse, misaligned access dropped

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- Memory op = ex_valid & (ex_mem_read | ex_mem_write). Aligned unless: halfword (funct3[1:0]=01) with addr[0]=1, or word (funct3[1:0]=10) with addr[1:0]≠0. Unlisted funct3 values are treated as word.
- IDLE, non-memory valid op: no stall; WB register loads {ex_alu_result, rd, reg_write} at the next edge.
- IDLE, aligned memory op: mem_stall=1, next state REQ.
- IDLE, misaligned memory op: no request, no stall; misaligned=1 this cycle; WB loads wb_valid=1, wb_reg_write=0.
- REQ: dmem_req_valid=1, mem_stall=1. dmem_addr = {addr[XLEN-1:2],2'b00}; dmem_we = ex_mem_write.
  - Byte enables: SB → 0001<<addr[1:0]; SH → 0011<<addr[1:0]; SW → 1111; loads → 1111.
  - dmem_wdata: SB → {4{rs2[7:0]}}; SH → {2{rs2[15:0]}}; SW → rs2.
  - On dmem_req_ready: store → DONE, load → RESP.
  - Request fields are stable while valid is high and not yet accepted.
- RESP: mem_stall=1. On dmem_rsp_valid, capture into the load buffer, then go to DONE.
  - Byte/half selected by addr[1:0]/addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is passed through.
- DONE: mem_stall=0. WB loads wb_write_data = load buffer (loads) or ex_alu_result (stores). Next state IDLE.
- WB register update at each edge:
  - mem_stall=1 → bubble (wb_valid=0, wb_reg_write=0).
  - Otherwise wb_valid = ex_valid and wb_reg_write = ex_valid & ex_reg_write.
- ex_* inputs are held stable by upstream while mem_stall=1.
- dmem_rsp_valid outside RESP is ignored.

## Timing
- Reset (async, active-low): state IDLE. wb_valid, wb_reg_write, wb_write_data, wb_rd_addr, dmem_req_valid, misaligned and mem_stall are all 0.
- Forwarding taps and dmem_we/be/wdata/addr are combinational from ex_*.
- Latency to wb_valid:
  - Non-memory op: 1 cycle.
  - Store: 3 cycles minimum (IDLE, REQ, DONE).
  - Load: 4 cycles minimum (IDLE, REQ, RESP, DONE). The response arrives no earlier than the cycle after acceptance.
- Each REQ cycle without ready adds 1 cycle; each RESP cycle without rsp_valid adds 1 cycle.
- Reset mid-transaction: request is dropped immediately, state returns to IDLE, and a late response is ignored.

## Test plan
- ADD result 0x0000_1234, rd=5, ex_valid=1 → next cycle wb_valid=1, wb_write_data=0x0000_1234, wb_rd_addr=5, mem_stall never asserted.
- SB rs2=0xAABB_CCDD, addr=0x103, ready immediate → dmem_addr=0x100, be=1000, wdata=0xDDDD_DDDD, we=1; stall for 2 cycles; wb_valid on the 3rd edge, wb_reg_write=0.
- LB addr=0x202, rdata=0x0080_0000 with 2 wait cycles on ready and 1 on rsp → wb_write_data=0xFFFF_FF80. Repeat as LBU → 0x0000_0080. Stall length matches the added wait cycles.
- LH addr=0x201 → misaligned=1 for 1 cycle, no dmem_req_valid, wb_valid=1 with wb_reg_write=0, no stall.
- Load with ex_reg_write=1 → mem_reg_write=0. ALU op with rd=7 → mem_reg_write=1, mem_rd_addr=7.
- reset driven low while in RESP → outputs zero immediately. After release, a stray dmem_rsp_valid produces no wb_valid.
